video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Parametrised raster timing generator for the HDMI output path. It produces the horizontal and vertical pixel counters and the DE, HSYNC and VSYNC signals, plus frame-start and line-start strobes, all registered and mutually aligned. Resolution, porches, sync widths and sync polarity are set by parameters. It replaces stand-alone DE decoding driven by external counters and feeds the overlay mixer and TMDS encoder directly.

Parameters:
busWidth, 12, width of hCount/vCount; must hold H_TOTAL-1 and V_TOTAL-1
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch in pixels (>=1)
H_SYNC, 44, hsync width in pixels (>=1)
H_BP, 148, horizontal back porch in pixels (>=1)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch in lines (>=1)
V_SYNC, 5, vsync width in lines (>=1)
V_BP, 36, vertical back porch in lines (>=1)
HS_POL, 1, hSync active level (1 = active-high)
VS_POL, 1, vSync active level

Ports:
clock  in  1  pixel clock; single clock domain
reset  in  1  asynchronous, active-high reset
enable  in  1  advance one pixel per clock when high; hold all state when low
hCount  out  busWidth  current horizontal position, 0..H_TOTAL-1
vCount  out  busWidth  current vertical position, 0..V_TOTAL-1
deOut  out  1  data enable
hSync  out  1  horizontal sync, polarity HS_POL
vSync  out  1  vertical sync, polarity VS_POL
lineStart  out  1  one-cycle strobe at hCount==0
frameStart  out  1  one-cycle strobe at hCount==0 && vCount==0
vBlank  out  1  high while vCount>=V_ACTIVE

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Line order: active, FP, sync, BP.
- Elaboration error if any porch or sync width is 0, or if H_TOTAL-1 or V_TOTAL-1 does not fit in busWidth.
- Reset (asynchronous assert): hCount=H_TOTAL-1, vCount=V_TOTAL-1, deOut=0, hSync=~HS_POL, vSync=~VS_POL, lineStart=0, frameStart=0, vBlank=1. These values equal the decode of the last raster position, so outputs are self-consistent during reset.
- On each clock edge with enable=1:
  - hCount increments. At H_TOTAL-1 it wraps to 0.
  - vCount increments only on an hCount wrap. At V_TOTAL-1 it wraps to 0.
  - The first enabled edge after reset therefore yields (0,0) with frameStart=1.
- enable=0: every output, strobes included, holds its previous value. A strobe that is high stays high until the next enabled edge.
- All outputs are registered and decoded from the new position in the same edge. deOut, hSync, vSync, strobes and vBlank always correspond to the hCount/vCount values presented on the same cycle (zero relative skew, one register stage).
- deOut = (hCount < H_ACTIVE) && (vCount < V_ACTIVE). Both conditions are ANDed, never sequentially overwritten.
- hSync is active for H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC.
- vSync is active for whole lines with V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC. Its edges coincide with hCount==0.
- Counter arithmetic is unsigned and busWidth wide. Comparisons use constants precomputed at elaboration; no multipliers.
- Reset asserted mid-frame: immediate return to the reset values. Restart is clean, with frameStart on the first enabled edge after release.

Decomposition:
- Package video_timing_pkg:
  - standard mode constant sets (1080p60, 720p60, 640x480p60) as H_ACTIVE..V_BP tuples;
  - a function computing total and sync-start/sync-end boundaries.
- Sub-module timing_axis_counter (parameters: width, ACTIVE, FP, SYNC, BP, POL):
  - inputs: step, plus the same clock/reset;
  - outputs: count, active, sync, wrap, zero.
  - Instantiated twice. The horizontal instance steps on enable; the vertical instance steps on enable && hWrap.

Test Plan (small config: H 8/2/3/2 so H_TOTAL=15; V 4/1/2/1 so V_TOTAL=8; busWidth 5; HS_POL=VS_POL=1):
1. Reset asserted, then released with enable=1 -> during reset hCount=14, vCount=7, deOut=0, hSync=0, vBlank=1. First edge gives (0,0) with frameStart=1, lineStart=1, deOut=1.
2. Run one full line -> deOut=1 for hCount 0..7 only; hSync=1 for hCount 10..12 only; hCount wraps 14->0 and vCount goes 0->1.
3. Run one full frame (120 enabled cycles) -> vSync=1 for vCount 5..6 (30 cycles); deOut count=32; frameStart exactly once; vBlank=1 for vCount 4..7.
4. Toggle enable low for 5 cycles at hCount=3 and at the frameStart cycle -> all outputs frozen, including frameStart held at 1. Resumes at hCount=4 with no skipped or duplicated position.
5. Assert reset at (hCount=11, vCount=5) -> outputs go to reset values asynchronously before the next edge. After release, the raster restarts at (0,0).
6. Repeat scenario 3 with HS_POL=VS_POL=0 and with the 1080p60 package constants -> sync levels are inverted. 1080p gives 2200x1125 totals and a hSync rising edge at hCount=2008.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing constants and boundary helper for the raster timing generator.
// Mode tuples are (active, front porch, sync, back porch) for each axis.
package video_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } mode_t;

    localparam mode_t MODE_1080P60 = '{
        h_active: 1920, h_fp: 88, h_sync: 44, h_bp: 148,
        v_active: 1080, v_fp: 4,  v_sync: 5,  v_bp: 36
    };

    localparam mode_t MODE_720P60 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
    };

    localparam mode_t MODE_640X480P60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    typedef struct packed {
        int unsigned total;
        int unsigned sync_start;
        int unsigned sync_end;
    } axis_bounds_t;

    // Axis order is active, front porch, sync, back porch; sync_end is exclusive.
    function automatic axis_bounds_t axis_bounds(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        axis_bounds_t b;
        b.sync_start = active + fp;
        b.sync_end   = b.sync_start + sync;
        b.total      = b.sync_end + bp;
        return b;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter plus registered active/sync/zero decode.
// wrap flags the last position so a slower axis can step on it.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int ACTIVE = 1920,
    parameter int FP     = 88,
    parameter int SYNC   = 44,
    parameter int BP     = 148,
    parameter bit POL    = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    output logic [WIDTH-1:0] count,
    output logic             active,
    output logic             sync,
    output logic             wrap,
    output logic             zero
);

    localparam axis_bounds_t BND = axis_bounds(ACTIVE, FP, SYNC, BP);

    localparam logic [WIDTH-1:0] LAST       = WIDTH'(BND.total - 1);
    localparam logic [WIDTH-1:0] ACT_END    = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] SYNC_START = WIDTH'(BND.sync_start);
    localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(BND.sync_end);

    if (FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_len
        $error("timing_axis_counter: porch and sync widths must be at least 1");
    end

    if (((BND.total - 1) >> WIDTH) != 0) begin : g_bad_width
        $error("timing_axis_counter: total-1 does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             active_q, active_d;
    logic             sync_q, sync_d;
    logic             zero_q, zero_d;

    // Decode runs on the next position so flags and count land on the same edge.
    always_comb begin
        count_d = count_q;
        if (step) begin
            count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
        end
        active_d = (count_d < ACT_END);
        sync_d   = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? POL : ~POL;
        zero_d   = (count_d == '0);
    end

    // Reset values are the decode of LAST, which lies in the back porch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= LAST;
            active_q <= 1'b0;
            sync_q   <= ~POL;
            zero_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            sync_q   <= sync_d;
            zero_q   <= zero_d;
        end
    end

    assign count  = count_q;
    assign active = active_q;
    assign sync   = sync_q;
    assign zero   = zero_q;
    assign wrap   = (count_q == LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with DE, syncs and strobes.
// Every output comes from the same register stage, so all signals share one position.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int busWidth = 12,
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [busWidth-1:0] hCount,
    output logic [busWidth-1:0] vCount,
    output logic                deOut,
    output logic                hSync,
    output logic                vSync,
    output logic                lineStart,
    output logic                frameStart,
    output logic                vBlank
);

    logic h_active, h_sync, h_wrap, h_zero;
    logic v_active, v_sync, v_zero;
    logic v_wrap_unused;
    logic v_step;

    assign v_step = enable && h_wrap;

    timing_axis_counter #(
        .WIDTH  (busWidth),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h_axis (
        .clock  (clock),
        .reset  (reset),
        .step   (enable),
        .count  (hCount),
        .active (h_active),
        .sync   (h_sync),
        .wrap   (h_wrap),
        .zero   (h_zero)
    );

    // Vertical axis advances on the same edge that wraps the horizontal one,
    // so vSync edges fall on hCount==0.
    timing_axis_counter #(
        .WIDTH  (busWidth),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v_axis (
        .clock  (clock),
        .reset  (reset),
        .step   (v_step),
        .count  (vCount),
        .active (v_active),
        .sync   (v_sync),
        .wrap   (v_wrap_unused),
        .zero   (v_zero)
    );

    assign deOut      = h_active && v_active;
    assign hSync      = h_sync;
    assign vSync      = v_sync;
    assign lineStart  = h_zero;
    assign frameStart = h_zero && v_zero;
    assign vBlank     = ~v_active;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small config in both polarities plus a 1080p instance,
// checked against a linear-pixel-index raster model.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic de, hs, vs, ls, fs, vb;
    } outs_t;

    typedef struct packed {
        logic  en;
        outs_t exp;
    } vec_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    logic clock, reset, enable;

    logic [4:0]  a_h, a_v, b_h, b_v;
    logic [11:0] c_h, c_v;
    logic a_de, a_hs, a_vs, a_ls, a_fs, a_vb;
    logic b_de, b_hs, b_vs, b_ls, b_fs, b_vb;
    logic c_de, c_hs, c_vs, c_ls, c_fs, c_vb;

    int n_tests = 0;
    int n_fail  = 0;
    cfg_t cfgs[3];
    int p[3];

    video_timing_gen #(
        .busWidth(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .hCount(a_h), .vCount(a_v),
        .deOut(a_de), .hSync(a_hs), .vSync(a_vs), .lineStart(a_ls), .frameStart(a_fs),
        .vBlank(a_vb)
    );

    video_timing_gen #(
        .busWidth(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .hCount(b_h), .vCount(b_v),
        .deOut(b_de), .hSync(b_hs), .vSync(b_vs), .lineStart(b_ls), .frameStart(b_fs),
        .vBlank(b_vb)
    );

    video_timing_gen #(
        .busWidth(12),
        .H_ACTIVE(int'(MODE_1080P60.h_active)), .H_FP(int'(MODE_1080P60.h_fp)),
        .H_SYNC(int'(MODE_1080P60.h_sync)), .H_BP(int'(MODE_1080P60.h_bp)),
        .V_ACTIVE(int'(MODE_1080P60.v_active)), .V_FP(int'(MODE_1080P60.v_fp)),
        .V_SYNC(int'(MODE_1080P60.v_sync)), .V_BP(int'(MODE_1080P60.v_bp)),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_c (
        .clock(clock), .reset(reset), .enable(enable), .hCount(c_h), .vCount(c_v),
        .deOut(c_de), .hSync(c_hs), .vSync(c_vs), .lineStart(c_ls), .frameStart(c_fs),
        .vBlank(c_vb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic outs_t mk(input int h, input int v, input logic de, input logic hs,
                                 input logic vs, input logic ls, input logic fs, input logic vb);
        outs_t o;
        o.h = 16'(h); o.v = 16'(v);
        o.de = de; o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs; o.vb = vb;
        return o;
    endfunction

    function automatic int h_tot(input int k);
        return cfgs[k].ha + cfgs[k].hf + cfgs[k].hs + cfgs[k].hb;
    endfunction

    function automatic int f_tot(input int k);
        return h_tot(k) * (cfgs[k].va + cfgs[k].vf + cfgs[k].vs + cfgs[k].vb);
    endfunction

    // Raster position is a linear pixel index; h/v fall out of div/mod.
    function automatic outs_t model_out(input int k, input int pos);
        int h, v;
        logic hs_in, vs_in;
        h = pos % h_tot(k);
        v = pos / h_tot(k);
        hs_in = (h >= cfgs[k].ha + cfgs[k].hf) && (h < cfgs[k].ha + cfgs[k].hf + cfgs[k].hs);
        vs_in = (v >= cfgs[k].va + cfgs[k].vf) && (v < cfgs[k].va + cfgs[k].vf + cfgs[k].vs);
        return mk(h, v, (h < cfgs[k].ha) && (v < cfgs[k].va),
                  hs_in ? cfgs[k].hp : !cfgs[k].hp, vs_in ? cfgs[k].vp : !cfgs[k].vp,
                  h == 0, pos == 0, v >= cfgs[k].va);
    endfunction

    function automatic outs_t get_out(input int k);
        case (k)
            0: return mk(int'(a_h), int'(a_v), a_de, a_hs, a_vs, a_ls, a_fs, a_vb);
            1: return mk(int'(b_h), int'(b_v), b_de, b_hs, b_vs, b_ls, b_fs, b_vb);
            default: return mk(int'(c_h), int'(c_v), c_de, c_hs, c_vs, c_ls, c_fs, c_vb);
        endcase
    endfunction

    task automatic check_one(input string name, input int k, input outs_t exp);
        outs_t got;
        got = get_out(k);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b vb=%b want h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b vb=%b",
                         name, k, got.h, got.v, got.de, got.hs, got.vs, got.ls, got.fs, got.vb,
                         exp.h, exp.v, exp.de, exp.hs, exp.vs, exp.ls, exp.fs, exp.vb);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string name);
        for (int k = 0; k < 3; k++) check_one(name, k, model_out(k, p[k]));
    endtask

    task automatic reset_model();
        for (int k = 0; k < 3; k++) p[k] = f_tot(k) - 1;
    endtask

    task automatic step(input logic en);
        @(negedge clock);
        enable = en;
        @(posedge clock);
        #1;
        if (en) for (int k = 0; k < 3; k++) p[k] = (p[k] + 1) % f_tot(k);
        check_all("model");
    endtask

    task automatic run_to(input int target, input int limit);
        for (int i = 0; i < limit && p[0] != target; i++) step(1'b1);
        n_tests++;
        if (p[0] != target) begin
            n_fail++;
            $display("FAIL run_to timeout pos=%0d want %0d", p[0], target);
        end
    endtask

    task automatic async_reset_pulse(input string name);
        @(negedge clock);
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        reset_model();
        check_all(name);
        #2;
        reset = 1'b0;
    endtask

    vec_t vecs[17];
    outs_t rst_a, rst_b, rst_c;

    initial begin
        int cnt_vs, cnt_de, cnt_fs, cnt_vb, cnt_hs, cnt_bvs_low, cnt_bhs_low, rise_h;
        logic prev_hs;

        cfgs[0] = '{ha: 8, hf: 2, hs: 3, hb: 2, va: 4, vf: 1, vs: 2, vb: 1, hp: 1'b1, vp: 1'b1};
        cfgs[1] = '{ha: 8, hf: 2, hs: 3, hb: 2, va: 4, vf: 1, vs: 2, vb: 1, hp: 1'b0, vp: 1'b0};
        cfgs[2] = '{ha: 1920, hf: 88, hs: 44, hb: 148, va: 1080, vf: 4, vs: 5, vb: 36,
                    hp: 1'b1, vp: 1'b1};

        rst_a = mk(14, 7, 0, 0, 0, 0, 0, 1);
        rst_b = mk(14, 7, 0, 1, 1, 0, 0, 1);
        rst_c = mk(2199, 1124, 0, 0, 0, 0, 0, 1);

        // First line of the small raster after reset release, including one hold cycle.
        vecs[0]  = '{1'b1, mk(0,  0, 1, 0, 0, 1, 1, 0)};
        vecs[1]  = '{1'b0, mk(0,  0, 1, 0, 0, 1, 1, 0)};
        vecs[2]  = '{1'b1, mk(1,  0, 1, 0, 0, 0, 0, 0)};
        vecs[3]  = '{1'b1, mk(2,  0, 1, 0, 0, 0, 0, 0)};
        vecs[4]  = '{1'b1, mk(3,  0, 1, 0, 0, 0, 0, 0)};
        vecs[5]  = '{1'b1, mk(4,  0, 1, 0, 0, 0, 0, 0)};
        vecs[6]  = '{1'b1, mk(5,  0, 1, 0, 0, 0, 0, 0)};
        vecs[7]  = '{1'b1, mk(6,  0, 1, 0, 0, 0, 0, 0)};
        vecs[8]  = '{1'b1, mk(7,  0, 1, 0, 0, 0, 0, 0)};
        vecs[9]  = '{1'b1, mk(8,  0, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{1'b1, mk(9,  0, 0, 0, 0, 0, 0, 0)};
        vecs[11] = '{1'b1, mk(10, 0, 0, 1, 0, 0, 0, 0)};
        vecs[12] = '{1'b1, mk(11, 0, 0, 1, 0, 0, 0, 0)};
        vecs[13] = '{1'b1, mk(12, 0, 0, 1, 0, 0, 0, 0)};
        vecs[14] = '{1'b1, mk(13, 0, 0, 0, 0, 0, 0, 0)};
        vecs[15] = '{1'b1, mk(14, 0, 0, 0, 0, 0, 0, 0)};
        vecs[16] = '{1'b1, mk(0,  1, 1, 0, 0, 1, 0, 0)};

        reset  = 1'b1;
        enable = 1'b0;
        reset_model();
        repeat (2) @(posedge clock);
        #1;
        check_one("reset_vals", 0, rst_a);
        check_one("reset_vals", 1, rst_b);
        check_one("reset_vals", 2, rst_c);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].en);
            check_one($sformatf("vec%0d", i), 0, vecs[i].exp);
        end

        // One full frame of 120 positions starting at (0,1).
        cnt_vs = 0; cnt_de = 0; cnt_fs = 0; cnt_vb = 0; cnt_hs = 0;
        cnt_bvs_low = 0; cnt_bhs_low = 0;
        for (int i = 0; i < 120; i++) begin
            step(1'b1);
            cnt_vs += int'(a_vs); cnt_de += int'(a_de); cnt_fs += int'(a_fs);
            cnt_vb += int'(a_vb); cnt_hs += int'(a_hs);
            cnt_bvs_low += int'(!b_vs); cnt_bhs_low += int'(!b_hs);
        end
        check_int("frame_vsync_cycles", cnt_vs, 30);
        check_int("frame_de_cycles", cnt_de, 32);
        check_int("frame_start_count", cnt_fs, 1);
        check_int("frame_vblank_cycles", cnt_vb, 60);
        check_int("frame_hsync_cycles", cnt_hs, 24);
        check_int("inv_vsync_low_cycles", cnt_bvs_low, 30);
        check_int("inv_hsync_low_cycles", cnt_bhs_low, 24);

        run_to(18, 200);
        check_one("at_h3", 0, mk(3, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            check_one("hold_h3", 0, mk(3, 1, 1, 0, 0, 0, 0, 0));
        end
        step(1'b1);
        check_one("resume_h4", 0, mk(4, 1, 1, 0, 0, 0, 0, 0));

        run_to(0, 200);
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            check_one("hold_fs", 0, mk(0, 0, 1, 0, 0, 1, 1, 0));
        end
        step(1'b1);
        check_one("resume_after_fs", 0, mk(1, 0, 1, 0, 0, 0, 0, 0));

        run_to(86, 200);
        check_one("pre_async_rst", 0, mk(11, 5, 0, 1, 1, 0, 0, 1));
        async_reset_pulse("async_rst");
        check_one("async_rst_vals", 0, rst_a);
        check_one("async_rst_vals", 1, rst_b);
        step(1'b1);
        check_one("restart_origin", 0, mk(0, 0, 1, 0, 0, 1, 1, 0));
        check_one("restart_origin", 2, mk(0, 0, 1, 0, 0, 1, 1, 0));

        // 1080p: locate the hSync rising edge and the first line wrap.
        check_int("tot_h_1080", int'(axis_bounds(MODE_1080P60.h_active, MODE_1080P60.h_fp,
                  MODE_1080P60.h_sync, MODE_1080P60.h_bp).total), 2200);
        check_int("tot_v_1080", int'(axis_bounds(MODE_1080P60.v_active, MODE_1080P60.v_fp,
                  MODE_1080P60.v_sync, MODE_1080P60.v_bp).total), 1125);
        rise_h  = -1;
        prev_hs = c_hs;
        for (int i = 0; i < 2199; i++) begin
            step(1'b1);
            if (c_hs && !prev_hs && rise_h < 0) rise_h = int'(c_h);
            prev_hs = c_hs;
        end
        check_int("hs_rise_1080", rise_h, 2008);
        step(1'b1);
        check_one("line_wrap_1080", 2, mk(0, 1, 1, 0, 0, 1, 0, 0));

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset_pulse("rand_rst");
            else step($urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
